// File: rtl/c2c_cmd_responder_if.sv
// Host command bus of the c2c target endpoint.
// The host (master) issues commands and data and polls busy/wd.
// The responder (slave) returns translation results.
interface c2c_cmd_responder_if;
  logic [1:0] cmd;        // 00 NOP, 01 write cache, 10 load CAM, 11 translate
  logic [7:0] datain;     // write byte, or VPN in [3:0] for translate
  logic       datavalid;  // qualifies datain during write
  logic [3:0] PID;        // process ID for translate
  logic [7:0] dataout;    // PPN result, 0 on fault
  logic       busy;       // multi-cycle operation in progress
  logic       outvalid;   // one-cycle translate-result strobe
  logic       pagefault;  // one-cycle miss strobe alongside outvalid
  logic       wd;         // write ready / write done

  modport master (
    output cmd, datain, datavalid, PID,
    input  dataout, busy, outvalid, pagefault, wd
  );

  modport slave (
    input  cmd, datain, datavalid, PID,
    output dataout, busy, outvalid, pagefault, wd
  );
endinterface

// File: rtl/c2c_cmd_responder.sv
// Target-side endpoint of the c2c command protocol.
// Buffers a translation table into a byte cache, loads it into a CAM of
// DEPTH slots, and answers {PID,VPN} lookups with a PPN or a page fault.
// Cache layout: byte 0 = entry count N, entry i = key at 1+2i, PPN at 2+2i.
module c2c_cmd_responder #(
  parameter int DEPTH = 10
) (
  input logic                 clk,
  input logic                 rst,
  c2c_cmd_responder_if.slave  bus
);

  localparam int CBYTES = 2 * DEPTH + 1;
  localparam int CW     = $clog2(CBYTES);
  localparam int SW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] LAST_BYTE = CW'(2 * DEPTH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_LOAD,
    S_SEARCH,
    S_RESP
  } state_t;

  // Control and output registers
  state_t           r_state;
  logic [CW-1:0]    r_wcnt;
  logic [SW-1:0]    r_slot;
  logic [7:0]       r_key;
  logic             r_hit;
  logic [7:0]       r_ppn;
  logic [DEPTH-1:0] r_cam_valid;
  logic             r_busy;
  logic             r_wd;
  logic             r_outvalid;
  logic             r_pagefault;
  logic [7:0]       r_dataout;

  // Storage arrays
  logic [7:0] r_cache   [0:CBYTES-1];
  logic [7:0] r_cam_key [0:DEPTH-1];
  logic [7:0] r_cam_ppn [0:DEPTH-1];

  // Load-path addressing and search results
  logic [CW-1:0] w_key_addr;
  logic [CW-1:0] w_ppn_addr;
  logic [7:0]    w_entry_cnt;
  logic          w_slot_valid;
  logic          w_hit;
  logic [7:0]    w_hit_ppn;

  assign w_key_addr   = CW'({r_slot, 1'b0}) + CW'(1);
  assign w_ppn_addr   = w_key_addr + CW'(1);
  // Entry counts above DEPTH clamp to a full CAM.
  assign w_entry_cnt  = (r_cache[0] > 8'(DEPTH)) ? 8'(DEPTH) : r_cache[0];
  assign w_slot_valid = (8'(r_slot) < w_entry_cnt);

  // Parallel compare of the latched key against every valid slot; lowest index wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise paths that do not assign it infer a latch.
    w_hit     = 1'b0;
    w_hit_ppn = 8'h00;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_cam_valid[i] && (r_cam_key[i] == r_key)) begin
        w_hit     = 1'b1;
        w_hit_ppn = r_cam_ppn[i];
      end
    end
  end

  // Cache fill: one byte per accepted datavalid cycle while writing.
  // NOTE: storage arrays have no reset; their contents are only consumed
  // after being written, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if ((r_state == S_WRITE) && bus.datavalid) begin
      r_cache[r_wcnt] <= bus.datain;
    end
  end

  // CAM key/PPN transfer from the cache, one slot per LOAD cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_cam_key[r_slot] <= r_cache[w_key_addr];
      r_cam_ppn[r_slot] <= r_cache[w_ppn_addr];
    end
  end

  // Command FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_slot      <= '0;
      r_key       <= 8'h00;
      r_hit       <= 1'b0;
      r_ppn       <= 8'h00;
      r_cam_valid <= '0;
      r_busy      <= 1'b0;
      r_wd        <= 1'b0;
      r_outvalid  <= 1'b0;
      r_pagefault <= 1'b0;
      r_dataout   <= 8'h00;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_outvalid  <= 1'b0;
      r_pagefault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          case (bus.cmd)
            2'b01: begin
              r_wcnt  <= '0;
              r_wd    <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_WRITE;
            end
            2'b10: begin
              // A load is only meaningful once a write has been issued.
              if (r_wd) begin
                r_slot  <= '0;
                r_busy  <= 1'b1;
                r_state <= S_LOAD;
              end
            end
            2'b11: begin
              r_key   <= {bus.PID, bus.datain[3:0]};
              r_busy  <= 1'b1;
              r_state <= S_SEARCH;
            end
            default: ;
          endcase
        end
        S_WRITE: begin
          // Stalls (datavalid=0) simply wait; there is no timeout.
          if (bus.datavalid) begin
            if (r_wcnt == LAST_BYTE) begin
              r_busy  <= 1'b0;
              r_wd    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_wcnt <= r_wcnt + CW'(1);
            end
          end
        end
        S_LOAD: begin
          r_cam_valid[r_slot] <= w_slot_valid;
          if (r_slot == LAST_SLOT) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_slot <= r_slot + SW'(1);
          end
        end
        S_SEARCH: begin
          r_hit   <= w_hit;
          r_ppn   <= w_hit_ppn;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_busy      <= 1'b0;
          r_outvalid  <= 1'b1;
          r_dataout   <= r_hit ? r_ppn : 8'h00;
          r_pagefault <= ~r_hit;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dataout   = r_dataout;
  assign bus.busy      = r_busy;
  assign bus.outvalid  = r_outvalid;
  assign bus.pagefault = r_pagefault;
  assign bus.wd        = r_wd;

endmodule
